// File: rtl/test_monitor_pkg.sv
// Shared types and helpers for the pass/fail test monitor.
// Holds the global FSM states, the per-channel verdict type and the index-width helper.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mon_state_t;

  typedef enum logic [1:0] {
    CH_PENDING,
    CH_PASS,
    CH_FAIL
  } ch_verdict_t;

  // Index width that stays legal for a single channel.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/test_monitor_ch.sv
// One monitored status channel: a code must be held for STABLE_CYCLES samples in RUN
// before it latches as a sticky pass or fail verdict.
module test_monitor_ch
  import test_monitor_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter logic [DATA_W-1:0] PASS_CODE     = DATA_W'(8'hFF),
  parameter logic [DATA_W-1:0] FAIL_CODE     = DATA_W'(8'hEE),
  parameter int                STABLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic [DATA_W-1:0] status,
  output ch_verdict_t       verdict
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);

  logic [SC_W-1:0] cnt_q, cnt_d;
  logic            last_pass_q, last_pass_d;
  logic            is_pass, is_fail;
  ch_verdict_t     verdict_q, verdict_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    is_pass     = (status == PASS_CODE);
    is_fail     = (status == FAIL_CODE);
    cnt_d       = cnt_q;
    last_pass_d = last_pass_q;
    verdict_d   = verdict_q;
    if (run && (verdict_q == CH_PENDING)) begin
      last_pass_d = is_pass;
      if (is_pass || is_fail) begin
        // A non-zero count means the previous sample was a code; extend only if it is the same one.
        if ((cnt_q != '0) && (last_pass_q == is_pass)) cnt_d = cnt_q + SC_W'(1);
        else                                          cnt_d = SC_W'(1);
      end else begin
        cnt_d = '0;
      end
      if (cnt_d == SC_W'(STABLE_CYCLES)) verdict_d = is_pass ? CH_PASS : CH_FAIL;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst || clear) begin
      cnt_q       <= '0;
      last_pass_q <= 1'b0;
      verdict_q   <= CH_PENDING;
    end else begin
      cnt_q       <= cnt_d;
      last_pass_q <= last_pass_d;
      verdict_q   <= verdict_d;
    end
  end

  assign verdict = verdict_q;

endmodule

// File: rtl/test_monitor.sv
// Synthesizable test-completion monitor: per-channel stable pass/fail latching,
// a RUN-cycle watchdog and a sticky overall verdict.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int                NUM_CH         = 1,
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] PASS_CODE      = DATA_W'(8'hFF),
  parameter logic [DATA_W-1:0] FAIL_CODE      = DATA_W'(8'hEE),
  parameter int                STABLE_CYCLES  = 2,
  parameter int                TIMEOUT_CYCLES = 1000000,
  parameter bit                STOP_ON_FAIL   = 1'b1,
  parameter int                CNT_W          = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [NUM_CH*DATA_W-1:0]   status_i,
  output logic                       done_o,
  output logic                       done_pulse_o,
  output logic                       pass_o,
  output logic                       timeout_o,
  output logic [NUM_CH-1:0]          pass_mask_o,
  output logic [NUM_CH-1:0]          fail_mask_o,
  output logic [idx_w(NUM_CH)-1:0]   first_fail_o,
  output logic [CNT_W-1:0]           cycles_o
);

  localparam int               IDX_W       = idx_w(NUM_CH);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  mon_state_t        state_q, state_d;
  ch_verdict_t       verdict [NUM_CH];
  logic [NUM_CH-1:0] pass_mask, fail_mask;
  logic              stop_fail, all_done, wd_expired, timeout_hit, finish, run;
  logic [CNT_W-1:0]  cycles_q;
  logic              done_q, pulse_q, pass_q, timeout_q;
  logic              ff_seen_q;
  logic [IDX_W-1:0]  ff_idx_q, ff_lowest;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    test_monitor_ch #(
      .DATA_W        (DATA_W),
      .PASS_CODE     (PASS_CODE),
      .FAIL_CODE     (FAIL_CODE),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_i),
      .run     (run),
      .status  (status_i[c*DATA_W +: DATA_W]),
      .verdict (verdict[c])
    );
    assign pass_mask[c] = (verdict[c] == CH_PASS);
    assign fail_mask[c] = (verdict[c] == CH_FAIL);
  end

  always_comb begin
    stop_fail   = STOP_ON_FAIL && (|fail_mask);
    all_done    = &(pass_mask | fail_mask);
    wd_expired  = (TIMEOUT_CYCLES != 0) && (cycles_q == TIMEOUT_VAL);
    timeout_hit = wd_expired && !stop_fail && !all_done;
    finish      = (state_q == RUN) && (stop_fail || all_done || wd_expired);
    // Channels and the counter freeze on the edge that enters DONE, so the verdict matches the masks.
    run         = (state_q == RUN) && !finish;
    state_d     = state_q;
    unique case (state_q)
      IDLE:    if (enable_i) state_d = RUN;
      RUN:     if (finish)   state_d = DONE;
      default: ;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Lowest-index failing channel, used until the first fail is captured.
  always_comb begin
    ff_lowest = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (fail_mask[c]) ff_lowest = IDX_W'(c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q   <= IDLE;
      cycles_q  <= '0;
      done_q    <= 1'b0;
      pulse_q   <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      ff_seen_q <= 1'b0;
      ff_idx_q  <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= finish;
      if (run && (cycles_q != '1)) cycles_q <= cycles_q + CNT_W'(1);
      if (finish) begin
        done_q    <= 1'b1;
        timeout_q <= timeout_hit;
        pass_q    <= (&pass_mask) & ~timeout_hit;
      end
      if (!ff_seen_q && (|fail_mask)) begin
        ff_seen_q <= 1'b1;
        ff_idx_q  <= ff_lowest;
      end
    end
  end

  assign done_o       = done_q;
  assign done_pulse_o = pulse_q;
  assign pass_o       = pass_q;
  assign timeout_o    = timeout_q;
  assign pass_mask_o  = pass_mask;
  assign fail_mask_o  = fail_mask;
  assign first_fail_o = ff_seen_q ? ff_idx_q : ff_lowest;
  assign cycles_o     = cycles_q;

endmodule

// File: tb/tb_test_monitor.sv
// Self-checking bench for test_monitor: three differently parametrised instances run
// directed scenarios and random status traffic against a sample-history reference model.
module tb_test_monitor;

  localparam int NI = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic rst, enable, clear;
  logic [7:0] stat [NI][4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance parameters: 0 = defaults, 1 = 4ch/stable3/timeout40, 2 = 2ch/no-stop/no-watchdog.
  function automatic int nch(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 2;
  endfunction
  function automatic int stb(input int i);
    return (i == 1) ? 3 : 2;
  endfunction
  function automatic int tlim(input int i);
    return (i == 0) ? 1000000 : (i == 1) ? 40 : 0;
  endfunction
  function automatic bit sof(input int i);
    return (i != 2);
  endfunction

  logic [7:0]  s0;
  logic [31:0] s1;
  logic [15:0] s2;
  assign s0 = stat[0][0];
  assign s1 = {stat[1][3], stat[1][2], stat[1][1], stat[1][0]};
  assign s2 = {stat[2][1], stat[2][0]};

  logic        done_w [NI], pulse_w [NI], pass_w [NI], tmo_w [NI];
  logic [31:0] cyc_w [NI];
  logic [0:0]  pm0, fm0, ff0, ff2;
  logic [3:0]  pm1, fm1;
  logic [1:0]  ff1, pm2, fm2;

  test_monitor dut0 (
    .clk(clk), .rst(rst), .enable_i(enable), .clear_i(clear), .status_i(s0),
    .done_o(done_w[0]), .done_pulse_o(pulse_w[0]), .pass_o(pass_w[0]), .timeout_o(tmo_w[0]),
    .pass_mask_o(pm0), .fail_mask_o(fm0), .first_fail_o(ff0), .cycles_o(cyc_w[0])
  );

  test_monitor #(.NUM_CH(4), .STABLE_CYCLES(3), .TIMEOUT_CYCLES(40), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .enable_i(enable), .clear_i(clear), .status_i(s1),
    .done_o(done_w[1]), .done_pulse_o(pulse_w[1]), .pass_o(pass_w[1]), .timeout_o(tmo_w[1]),
    .pass_mask_o(pm1), .fail_mask_o(fm1), .first_fail_o(ff1), .cycles_o(cyc_w[1])
  );

  test_monitor #(.NUM_CH(2), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(0), .STOP_ON_FAIL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .enable_i(enable), .clear_i(clear), .status_i(s2),
    .done_o(done_w[2]), .done_pulse_o(pulse_w[2]), .pass_o(pass_w[2]), .timeout_o(tmo_w[2]),
    .pass_mask_o(pm2), .fail_mask_o(fm2), .first_fail_o(ff2), .cycles_o(cyc_w[2])
  );

  // Reference model: keeps the recent RUN samples of each channel and latches a channel
  // when its newest STABLE samples are all the same pass or fail code.
  int          m_st [NI];
  logic [31:0] m_cyc [NI];
  bit          m_done [NI], m_pulse [NI], m_pass [NI], m_tmo [NI], m_ffset [NI];
  logic [3:0]  m_pm [NI], m_fm [NI];
  int          m_ff [NI];
  logic [7:0]  hist [NI][4][4];
  int          hn [NI][4];

  function automatic logic [3:0] full(input int i);
    return 4'((1 << nch(i)) - 1);
  endfunction

  task automatic model_reset(input int i);
    m_st[i] = M_IDLE; m_cyc[i] = 0; m_done[i] = 0; m_pulse[i] = 0; m_pass[i] = 0;
    m_tmo[i] = 0; m_pm[i] = 0; m_fm[i] = 0; m_ff[i] = 0; m_ffset[i] = 0;
    for (int c = 0; c < 4; c++) hn[i][c] = 0;
  endtask

  task automatic model_step(input int i);
    bit stopf, allv, fin, same;
    m_pulse[i] = 0;
    if (rst || clear) begin
      model_reset(i);
    end else if (m_st[i] == M_IDLE) begin
      if (enable) m_st[i] = M_RUN;
    end else if (m_st[i] == M_RUN) begin
      stopf = sof(i) && (m_fm[i] != 0);
      allv  = ((m_pm[i] | m_fm[i]) == full(i));
      fin   = stopf || allv || (tlim(i) != 0 && m_cyc[i] == 32'(tlim(i)));
      if (fin) begin
        m_st[i] = M_DONE; m_done[i] = 1; m_pulse[i] = 1;
        m_tmo[i]  = !stopf && !allv;
        m_pass[i] = (m_pm[i] == full(i)) && !m_tmo[i];
      end else begin
        if (m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 1;
        for (int c = 0; c < nch(i); c++) begin
          if (!m_pm[i][c] && !m_fm[i][c]) begin
            for (int k = 3; k > 0; k--) hist[i][c][k] = hist[i][c][k-1];
            hist[i][c][0] = stat[i][c];
            if (hn[i][c] < 4) hn[i][c]++;
            same = (hn[i][c] >= stb(i)) && (hist[i][c][0] == 8'hFF || hist[i][c][0] == 8'hEE);
            for (int k = 1; k < stb(i); k++) if (hist[i][c][k] !== hist[i][c][0]) same = 0;
            if (same) begin
              if (hist[i][c][0] == 8'hFF) m_pm[i][c] = 1'b1;
              else begin
                m_fm[i][c] = 1'b1;
                if (!m_ffset[i]) begin m_ffset[i] = 1; m_ff[i] = c; end
              end
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic compare_all(input int i);
    logic [31:0] pm, fm, ff;
    case (i)
      0:       begin pm = 32'(pm0); fm = 32'(fm0); ff = 32'(ff0); end
      1:       begin pm = 32'(pm1); fm = 32'(fm1); ff = 32'(ff1); end
      default: begin pm = 32'(pm2); fm = 32'(fm2); ff = 32'(ff2); end
    endcase
    check("done",       i, 32'(done_w[i]),  32'(m_done[i]));
    check("done_pulse", i, 32'(pulse_w[i]), 32'(m_pulse[i]));
    check("pass",       i, 32'(pass_w[i]),  32'(m_pass[i]));
    check("timeout",    i, 32'(tmo_w[i]),   32'(m_tmo[i]));
    check("pass_mask",  i, pm,              32'(m_pm[i]));
    check("fail_mask",  i, fm,              32'(m_fm[i]));
    check("first_fail", i, ff,              32'(m_ff[i]));
    check("cycles",     i, cyc_w[i],        m_cyc[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < NI; i++) compare_all(i);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic zero_stat();
    for (int i = 0; i < NI; i++) for (int c = 0; c < 4; c++) stat[i][c] = 8'h00;
  endtask

  task automatic start_run();
    clear = 1; tick(); clear = 0;
    zero_stat();
    enable = 1; tick(); enable = 0;
  endtask

  function automatic logic [7:0] pick_code();
    int r;
    r = $urandom_range(99);
    if (r < 40)      return 8'hFF;
    else if (r < 55) return 8'hEE;
    else if (r < 80) return 8'h00;
    else             return 8'($urandom);
  endfunction

  logic [7:0] glitch [6];

  initial begin
    glitch = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < NI; i++) model_reset(i);
    zero_stat();
    rst = 1; enable = 0; clear = 0;
    ticks(10);
    rst = 0;

    // Single channel passes: FF from RUN cycle 5, mask at cycle 7, pulse at 8, cycles frozen at 7.
    enable = 1; tick(); enable = 0;
    ticks(5);
    stat[0][0] = 8'hFF;
    ticks(2);
    check("tp1_mask_c7", 0, 32'(pm0), 1);
    check("tp1_notdone_c7", 0, 32'(done_w[0]), 0);
    tick();
    check("tp1_pulse_c8", 0, 32'(pulse_w[0]), 1);
    tick();
    check("tp1_pulse_gone", 0, 32'(pulse_w[0]), 0);
    check("tp1_pass", 0, 32'(pass_w[0]), 1);
    check("tp1_cycles", 0, cyc_w[0], 7);

    // Glitch rejection on the 3-cycle instance; a one-cycle FF pulse on ch1 never latches.
    start_run();
    for (int k = 0; k < 6; k++) begin
      stat[1][0] = glitch[k];
      stat[1][1] = (k == 1) ? 8'hFF : 8'h00;
      tick();
    end
    stat[1][0] = 8'h00;
    check("glitch_mask", 1, 32'(pm1), 32'h1);

    // Simultaneous fails on ch2/ch3; on the no-stop instance ch0 passes and ch1 fails later.
    start_run();
    stat[2][0] = 8'hFF;
    ticks(2);
    stat[1][2] = 8'hEE; stat[1][3] = 8'hEE; stat[2][1] = 8'hEE;
    ticks(2);
    check("nostop_wait", 2, 32'(done_w[2]), 0);
    ticks(4);
    check("sim_fail_mask", 1, 32'(fm1), 32'hC);
    check("sim_first_fail", 1, 32'(ff1), 2);
    check("sim_done", 1, 32'(done_w[1]), 1);
    check("sim_pass", 1, 32'(pass_w[1]), 0);
    check("nostop_done", 2, 32'(done_w[2]), 1);
    check("nostop_pm", 2, 32'(pm2), 32'h1);
    check("nostop_fm", 2, 32'(fm2), 32'h2);

    // Watchdog expiry with status stuck at 00.
    start_run();
    ticks(45);
    check("wd_timeout", 1, 32'(tmo_w[1]), 1);
    check("wd_done", 1, 32'(done_w[1]), 1);
    check("wd_cycles", 1, cyc_w[1], 40);

    // Every channel latches exactly when cycles_o reaches the limit: completion wins.
    start_run();
    ticks(37);
    for (int c = 0; c < 4; c++) stat[1][c] = 8'hFF;
    ticks(8);
    check("race_timeout", 1, 32'(tmo_w[1]), 0);
    check("race_pass", 1, 32'(pass_w[1]), 1);
    check("race_cycles", 1, cyc_w[1], 40);

    // Clear in DONE, clear in RUN with enable held, then rst mid-RUN.
    clear = 1; tick(); clear = 0;
    check("clr_done", 1, 32'(done_w[1]), 0);
    zero_stat();
    enable = 1; tick(); enable = 0;
    ticks(5);
    clear = 1; enable = 1; tick();
    check("clr_run_cycles", 0, cyc_w[0], 0);
    clear = 0; tick(); enable = 0;
    ticks(3);
    check("rerun_cycles", 0, cyc_w[0], 3);
    rst = 1; tick(); rst = 0;
    check("rst_cycles", 0, cyc_w[0], 0);
    enable = 1; tick(); enable = 0;
    ticks(2);
    check("after_rst_cycles", 0, cyc_w[0], 2);

    // Random traffic with occasional stray enables and clears.
    for (int r = 0; r < 25; r++) begin
      start_run();
      for (int k = 0; k < 60; k++) begin
        for (int i = 0; i < NI; i++)
          for (int c = 0; c < nch(i); c++)
            if ($urandom_range(99) < 30) stat[i][c] = pick_code();
        enable = ($urandom_range(99) < 10);
        clear  = ($urandom_range(199) == 0);
        tick();
      end
      enable = 0; clear = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
